// File: rtl/ad7606_ctrl.sv
// AD7606-family parallel-bus controller: CONVST pulse, BUSY handshake with timeout,
// CS/RD burst read of NUM_CH words, and optional periodic triggering with overrun reporting.
module ad7606_ctrl #(
    parameter int NUM_CH         = 8,
    parameter int DATA_W         = 16,
    parameter int CONVST_LOW_CYC = 2,
    parameter int RD_LOW_CYC     = 2,
    parameter int RD_HIGH_CYC    = 2,
    parameter int BUSY_TIMEOUT   = 1024,
    parameter int PERIOD_W       = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                busy_i,
    input  logic [DATA_W-1:0]   db_i,
    output logic                convst_o,
    output logic                cs_o,
    output logic                rd_o,
    output logic [DATA_W-1:0]   sample_o,
    output logic [2:0]          ch_o,
    output logic                valid_o,
    output logic                frame_done_o,
    output logic                busy_o,
    output logic                timeout_o,
    output logic                overrun_o
);

    localparam int CNT_MAX_A = (CONVST_LOW_CYC > RD_LOW_CYC) ? CONVST_LOW_CYC : RD_LOW_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > RD_HIGH_CYC) ? CNT_MAX_A : RD_HIGH_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int TO_W      = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONVST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RDL_LAST  = CNT_W'(RD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RDH_LAST  = CNT_W'(RD_HIGH_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [2:0]       CH_LAST   = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_HI,
        WAIT_LO,
        RD_L,
        RD_H,
        DONE
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    phase_cnt;
    logic [CNT_W-1:0]    phase_n;
    logic [TO_W-1:0]     to_cnt;
    logic [TO_W-1:0]     to_n;
    logic [2:0]          ch_cnt;
    logic [2:0]          ch_n;
    logic [PERIOD_W-1:0] period_cnt;
    logic                busy_meta;
    logic                busy_s;
    logic                trigger;
    logic                capture;
    logic                timeout_hit;
    logic                conv_start;
    logic                period_hit;
    logic                ovr_flag;

    // BUSY is asynchronous to clk_i; the FSM only ever looks at busy_s.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= busy_i;
            busy_s    <= busy_meta;
        end
    end

    assign trigger    = start_i || (cont_i && (period_cnt == '0));
    assign conv_start = (state == IDLE) && (state_n == CONV);
    assign period_hit = cont_i && (period_cnt == '0) && (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            phase_cnt <= '0;
            to_cnt    <= '0;
            ch_cnt    <= '0;
        end else begin
            state     <= state_n;
            phase_cnt <= phase_n;
            to_cnt    <= to_n;
            ch_cnt    <= ch_n;
        end
    end

    always_comb begin
        state_n     = state;
        phase_n     = phase_cnt;
        to_n        = to_cnt;
        ch_n        = ch_cnt;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_n = CONV;
                    phase_n = '0;
                end
            end
            CONV: begin
                if (phase_cnt == CONV_LAST) begin
                    state_n = WAIT_HI;
                    phase_n = '0;
                    to_n    = '0;
                end else begin
                    phase_n = phase_cnt + CNT_W'(1);
                end
            end
            // BUSY may not have risen yet (or the synchroniser has not caught it).
            WAIT_HI: begin
                if (busy_s) begin
                    state_n = WAIT_LO;
                    to_n    = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_n     = IDLE;
                    timeout_hit = 1'b1;
                    to_n        = '0;
                end else begin
                    to_n = to_cnt + TO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!busy_s) begin
                    state_n = RD_L;
                    phase_n = '0;
                    ch_n    = '0;
                    to_n    = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_n     = IDLE;
                    timeout_hit = 1'b1;
                    to_n        = '0;
                end else begin
                    to_n = to_cnt + TO_W'(1);
                end
            end
            RD_L: begin
                if (phase_cnt == RDL_LAST) begin
                    capture = 1'b1;
                    state_n = RD_H;
                    phase_n = '0;
                end else begin
                    phase_n = phase_cnt + CNT_W'(1);
                end
            end
            RD_H: begin
                if (phase_cnt == RDH_LAST) begin
                    phase_n = '0;
                    if (ch_cnt == CH_LAST) begin
                        state_n = DONE;
                    end else begin
                        ch_n    = ch_cnt + 3'd1;
                        state_n = RD_L;
                    end
                end else begin
                    phase_n = phase_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Period counter restarts at each conversion start; a 0 period behaves as 1.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            period_cnt <= '0;
            ovr_flag   <= 1'b0;
        end else begin
            if (conv_start) begin
                period_cnt <= (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
            end else if (period_cnt != '0) begin
                period_cnt <= period_cnt - PERIOD_W'(1);
            end
            if (conv_start) begin
                ovr_flag <= 1'b0;
            end else if (period_hit) begin
                ovr_flag <= 1'b1;
            end
        end
    end

    // Pin strobes are registered from the next state so they line up with the state
    // they belong to and never glitch. valid_o is a bare one-cycle strobe: there is no
    // ready, the consumer must accept sample_o/ch_o on every cycle valid_o is high.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            convst_o     <= 1'b1;
            cs_o         <= 1'b1;
            rd_o         <= 1'b1;
            sample_o     <= '0;
            ch_o         <= '0;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            convst_o     <= (state_n != CONV);
            cs_o         <= !((state_n == RD_L) || (state_n == RD_H));
            rd_o         <= (state_n != RD_L);
            valid_o      <= capture;
            frame_done_o <= (state_n == DONE);
            busy_o       <= (state_n != IDLE);
            timeout_o    <= timeout_hit;
            overrun_o    <= period_hit && !ovr_flag;
            if (capture) begin
                sample_o <= db_i;
                ch_o     <= ch_cnt;
            end
        end
    end

endmodule

// File: doc/ad7606_ctrl.md
Name: ad7606_ctrl

Overview:
- Parametrised FPGA-side controller for the AD7606-family parallel ADC.
- Generates CONVST, waits on BUSY, then reads NUM_CH words over the 16-bit parallel bus with CS/RD strobes.
- Presents each word to the fabric as a one-cycle valid pulse tagged with its channel index.
- Adds single-shot and continuous (periodic) modes, a BUSY timeout and overrun detection; sits between the ADC pins and the capture FIFO.

Parameters:
- NUM_CH, 8: channels read per conversion (1..8).
- DATA_W, 16: ADC data bus width.
- CONVST_LOW_CYC, 2: CONVST low pulse width in clocks (>=1).
- RD_LOW_CYC, 2: RD low width in clocks (>=1).
- RD_HIGH_CYC, 2: RD high width between reads in clocks (>=1).
- BUSY_TIMEOUT, 1024: max clocks allowed for each of the two BUSY waits before error.
- PERIOD_W, 16: width of the continuous-mode period register.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-shot trigger; sampled only in IDLE.
- cont_i  in  1  continuous mode enable.
- period_i  in  PERIOD_W  continuous-mode conversion period in clocks; 0 is treated as 1.
- busy_i  in  1  ADC BUSY, asynchronous to clk_i.
- db_i  in  DATA_W  ADC parallel data.
- convst_o  out  1  ADC CONVST, active-low pulse.
- cs_o  out  1  ADC chip select, active low.
- rd_o  out  1  ADC read strobe, active low.
- sample_o  out  DATA_W  captured word.
- ch_o  out  3  channel index of sample_o.
- valid_o  out  1  one-cycle strobe; sample_o/ch_o valid.
- frame_done_o  out  1  one-cycle pulse after the last channel.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- timeout_o  out  1  one-cycle pulse on BUSY timeout.
- overrun_o  out  1  one-cycle pulse when a continuous period expires while not in IDLE.

Behaviour:
- Reset values (sync, priority over all else):
  - convst_o=1, cs_o=1, rd_o=1.
  - sample_o=0, ch_o=0.
  - valid_o, frame_done_o, timeout_o, overrun_o = 0; busy_o=0.
  - FSM=IDLE; all counters 0.
- Reset asserted mid-operation:
  - All strobes return inactive on the next edge.
  - No valid_o or frame_done_o for the aborted frame.
- busy_i passes through a 2-flop synchroniser; busy_s lags the pin by 2 clocks. FSM uses busy_s only.
- FSM states: IDLE, CONV, WAIT_HI, WAIT_LO, RD_L, RD_H, DONE.
  - IDLE: on trigger, go to CONV.
    - Trigger is start_i=1, or (cont_i=1 and period counter expired).
    - Continuous mode with counter not expired: hold.
  - CONV: convst_o=0 for CONVST_LOW_CYC clocks, then convst_o=1 and go to WAIT_HI.
  - WAIT_HI: wait for busy_s=1.
    - Handles the case where BUSY has not yet risen.
    - If busy_s is already 0 after the rise window of BUSY_TIMEOUT clocks, go to timeout.
  - WAIT_LO: wait for busy_s=0; counter BUSY_TIMEOUT applies, reloaded on entry.
    - On busy_s=0: cs_o=0, ch counter=0, go to RD_L.
  - RD_L: rd_o=0 for RD_LOW_CYC clocks.
    - On the last clock of RD_L, register db_i into sample_o and ch counter into ch_o.
    - valid_o=1 on the following clock.
    - Then rd_o=1 and go to RD_H.
  - RD_H: rd_o=1 for RD_HIGH_CYC clocks.
    - If ch counter==NUM_CH-1, go to DONE; else increment ch and go to RD_L.
  - DONE: cs_o=1, frame_done_o=1 for one clock, then go to IDLE.
  - Timeout (either wait state): timeout_o=1 for one clock, cs_o=1, go to IDLE. No samples are emitted for that frame.
- Continuous mode:
  - Period counter reloads with max(period_i,1)-1 when CONV is entered and decrements each clock to 0.
  - Counter at 0 while FSM != IDLE: overrun_o pulses once and that trigger is dropped.
  - The next conversion starts on the first IDLE clock after the drop.
  - cont_i falling: the current frame completes; no new triggers.
- start_i while busy_o=1 is ignored, with no overrun pulse.
- start_i and cont_i trigger on the same IDLE clock produce a single conversion.
- Channel sequence is always 0..NUM_CH-1 with no gaps; ch_o never exceeds NUM_CH-1.

Test Plan:
- Defaults; single start_i pulse; BUSY model goes high 3 clk after CONVST rises and low 40 clk later; db_i = 0x1000+ch -> convst_o low exactly 2 clk; 8 valid_o pulses with ch_o 0..7 and sample_o 0x1000..0x1007; rd_o low 2 clk / high 2 clk; frame_done_o after ch 7; cs_o low only during reads.
- NUM_CH=4; repeat the previous stimulus -> exactly 4 samples (ch 0..3), then frame_done_o; no 5th RD strobe.
- busy_i held 0 forever after start_i -> timeout_o pulses once after BUSY_TIMEOUT clocks; returns to IDLE; no valid_o.
- cont_i=1, period_i=200, BUSY low time 40 -> CONVST falling edges exactly 200 clk apart over 5 frames; overrun_o never asserts.
- cont_i=1, period_i=20 (shorter than a frame) -> overrun_o pulses; every completed frame still delivers 8 ordered samples.
- reset_i asserted during RD_L of ch 3 -> next clock cs_o=rd_o=convst_o=1 and no further valid_o; a later start_i gives a clean frame starting at ch 0.
